ldpc_codeword_serializer: RTL and testbench
===========================================

// Module: ldpc_codeword_serializer
// PURPOSE
//  Downstream of the LDPC 802.3an encoder: captures one registered parallel codeword
//  (CW_WIDTH bits) per valid/ready handshake and emits it as CW_WIDTH/LANE_W lane beats.
//  Emits MSB lane first, with start/end-of-frame markers and a completed-frame counter.
//  Feeds the PCS/PMA transmit path; replaces the XOR-reduce observation point in bench builds.
// PARAMETERS
//  CW_WIDTH  2048  codeword width in bits; must be an integer multiple of LANE_W
//  LANE_W    32    output lane width in bits
//  FCNT_W    16    width of completed-frame counter
// PORTS
//  clk        in   1         single clock, all logic on rising edge
//  rst_n      in   1         synchronous reset, active-low
//  cw_valid   in   1         codeword present on cw_data
//  cw_data    in   CW_WIDTH  codeword; bit CW_WIDTH-1 is first transmitted bit
//  cw_ready   out  1         serializer can accept codeword this cycle
//  ser_valid  out  1         ser_data holds a valid beat
//  ser_data   out  LANE_W    current lane beat
//  ser_sof    out  1         high on first beat of a codeword
//  ser_eof    out  1         high on last beat of a codeword
//  ser_ready  in   1         downstream accepts beat this cycle
//  frame_cnt  out  FCNT_W    number of codewords fully emitted, wraps
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, ser_valid=0, beat_cnt=0, frame_cnt=0, shift reg=0.
//    cw_ready is 0 while rst_n=0; ser_sof/ser_eof are 0 whenever ser_valid=0.
//  - BEATS = CW_WIDTH/LANE_W; beat_cnt width $clog2(BEATS); elaboration error if not divisible.
//  - FSM IDLE: cw_ready=1. cw_valid&cw_ready -> load shift reg, beat_cnt=0, go SEND.
//  - FSM SEND: ser_valid=1, ser_data=shift[CW_WIDTH-1 -: LANE_W], ser_sof=(beat_cnt==0),
//    ser_eof=(beat_cnt==BEATS-1). ser_ready=0 -> hold all outputs stable (no change).
//    ser_ready=1 & not last -> shift left by LANE_W, beat_cnt+1.
//    ser_ready=1 & last -> frame_cnt+1 (wraps 2^FCNT_W-1 -> 0); cw_ready=1 this cycle
//    (combinational); if cw_valid also high, load next codeword and stay SEND, beat_cnt=0
//    (zero-bubble back-to-back); else go IDLE.
//  - cw_ready = (state==IDLE) | (state==SEND & ser_eof & ser_ready), gated by rst_n.
//  - Latency: codeword accepted at edge N -> first beat valid after edge N, no extra stage.
//  - cw_data is not sampled outside an accepted handshake; cw_valid without cw_ready is ignored
//    (upstream must hold).
//  - BEATS==1: every beat has sof=eof=1.
//  - Reset mid-frame: frame discarded, frame_cnt not incremented, outputs return to reset values.
// CONFIGURATION
//  LDPC_SER_PARITY_EN defined: adds output ser_parity (1 bit). On the eof beat it equals the
//   XOR of all CW_WIDTH bits of the frame (running XOR over emitted beats, cleared on load);
//   0 on all other beats and in reset. Matches XOR-reduce signature of the encoder output reg.
//  Undefined: port and running-XOR register absent; all other behaviour identical.
// STRUCTURE
//  Package ldpc_ser_pkg: state enum {IDLE, SEND}; localparam helpers BEATS, CNT_W;
//   default CW_WIDTH=2048/LANE_W=32 constants shared with encoder wrapper.
//  One sub-module: ldpc_ser_lane_shifter (CW_WIDTH shift reg, load/shift enables, MSB lane tap,
//   optional running XOR). FSM, beat counter, frame counter stay in top.
// TESTING
//  1 Reset then single frame, cw_data=0x8000...0001 (bit 2047 & bit 0), ser_ready=1 ->
//    64 beats, beat0=0x80000000 with sof, beat63=0x00000001 with eof, frame_cnt=1.
//  2 Random ser_ready stalls (50%) on random codeword -> reassembled beats equal cw_data,
//    ser_data/sof/eof stable across every stall cycle.
//  3 Back-to-back: cw_valid held high with 3 codewords, ser_ready=1 -> 192 consecutive valid
//    beats, no bubble, cw_ready high exactly on beats 63,127,191 (plus IDLE start).
//  4 rst_n=0 at beat 20 of frame -> next cycle ser_valid=0, frame_cnt unchanged, cw_ready=0
//    until rst_n=1; following frame starts at sof cleanly.
//  5 FCNT_W=4, send 17 frames -> frame_cnt reads 1 after wrap through 15->0.
//  6 LDPC_SER_PARITY_EN: all-ones codeword -> ser_parity=0 on eof; single bit set -> 1.

Source files
------------

// File: rtl/ldpc_ser_pkg.sv
`default_nettype none
// ============================================================================
// Module : ldpc_ser_pkg
// Brief  : Shared types and sizing helpers for the LDPC codeword serializer.
//          Holds the serializer state enum, default codeword/lane geometry
//          (shared with the encoder wrapper) and beat/counter width helpers.
//          Optional feature macro used by the serializer: LDPC_SER_PARITY_EN.
// Rev    : 1.0  initial release
// ============================================================================
package ldpc_ser_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  localparam int unsigned CW_WIDTH_DEFAULT = 2048;
  localparam int unsigned LANE_W_DEFAULT   = 32;
  localparam int unsigned FCNT_W_DEFAULT   = 16;

  // Number of lane beats needed to carry one codeword.
  function automatic int unsigned beats_of(input int unsigned cw_width,
                                           input int unsigned lane_w);
    return cw_width / lane_w;
  endfunction

  // Beat counter width; a single-beat codeword still needs a 1-bit counter.
  function automatic int unsigned cnt_w_of(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int unsigned BEATS = beats_of(CW_WIDTH_DEFAULT, LANE_W_DEFAULT);
  localparam int unsigned CNT_W = cnt_w_of(BEATS);

endpackage
`default_nettype wire

// File: rtl/ldpc_ser_lane_shifter.sv
`default_nettype none
// ============================================================================
// Module : ldpc_ser_lane_shifter
// Brief  : CW_WIDTH-bit shift register feeding the serializer output lane.
//          Loads a full codeword, shifts left by LANE_W per accepted beat and
//          taps the top LANE_W bits as the current lane.
//          With LDPC_SER_PARITY_EN defined it also keeps a running XOR of the
//          beats already emitted; frame_xor is that XOR folded with the
//          current lane, i.e. the XOR of the whole frame on its last beat.
// Ports  : clk, rst_n (sync, active-low), load, shift, load_data -> lane
//          [frame_xor when LDPC_SER_PARITY_EN]
// Rev    : 1.0  initial release
// ============================================================================
module ldpc_ser_lane_shifter #(
  parameter int unsigned CW_WIDTH = 2048,
  parameter int unsigned LANE_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                shift,
  input  logic [CW_WIDTH-1:0] load_data,
  output logic [LANE_W-1:0]   lane
`ifdef LDPC_SER_PARITY_EN
  ,
  output logic                frame_xor
`endif
);

  logic [CW_WIDTH-1:0] shreg;

  // Load wins over shift so a back-to-back codeword replaces the last beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= load_data;
    end else if (shift) begin
      shreg <= shreg << LANE_W;
    end
  end

  assign lane = shreg[CW_WIDTH-1 -: LANE_W];

`ifdef LDPC_SER_PARITY_EN
  logic xor_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xor_acc <= 1'b0;
    end else if (load) begin
      xor_acc <= 1'b0;
    end else if (shift) begin
      xor_acc <= xor_acc ^ (^lane);
    end
  end

  assign frame_xor = xor_acc ^ (^lane);
`endif

endmodule
`default_nettype wire

// File: rtl/ldpc_codeword_serializer.sv
`default_nettype none
// ============================================================================
// Module : ldpc_codeword_serializer
// Brief  : Accepts one CW_WIDTH-bit codeword per cw_valid/cw_ready handshake
//          and emits it MSB lane first as CW_WIDTH/LANE_W beats with sof/eof
//          markers and a wrapping completed-frame counter. Supports
//          zero-bubble back-to-back codewords.
// Ports  : clk, rst_n (sync, active-low)
//          cw_valid, cw_data -> cw_ready            (codeword input)
//          ser_valid, ser_data, ser_sof, ser_eof <- ser_ready (lane output)
//          frame_cnt                                (completed frames)
//          ser_parity (only with LDPC_SER_PARITY_EN): frame XOR on eof beat
// Rev    : 1.0  initial release
// ============================================================================
module ldpc_codeword_serializer
  import ldpc_ser_pkg::*;
#(
  parameter int unsigned CW_WIDTH = CW_WIDTH_DEFAULT,
  parameter int unsigned LANE_W   = LANE_W_DEFAULT,
  parameter int unsigned FCNT_W   = FCNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cw_valid,
  input  logic [CW_WIDTH-1:0] cw_data,
  output logic                cw_ready,
  output logic                ser_valid,
  output logic [LANE_W-1:0]   ser_data,
  output logic                ser_sof,
  output logic                ser_eof,
  input  logic                ser_ready,
  output logic [FCNT_W-1:0]   frame_cnt
`ifdef LDPC_SER_PARITY_EN
  ,
  output logic                ser_parity
`endif
);

  localparam int unsigned NBEATS = beats_of(CW_WIDTH, LANE_W);
  localparam int unsigned BCNT_W = cnt_w_of(NBEATS);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(NBEATS - 1);

  generate
    if ((LANE_W == 0) || ((CW_WIDTH % LANE_W) != 0)) begin : g_width_check
      $error("ldpc_codeword_serializer: CW_WIDTH must be a multiple of LANE_W");
    end
  endgenerate

  ser_state_t        state;
  ser_state_t        next_state;
  logic [BCNT_W-1:0] beat_cnt;
  logic              accept;
  logic              shift_en;
  logic              frame_done;

  // State register plus beat and frame counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        beat_cnt <= '0;
      end else if (shift_en) begin
        beat_cnt <= beat_cnt + BCNT_W'(1);
      end
      if (frame_done) begin
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end
    end
  end

  // Next-state and handshake decode. cw_ready opens combinationally on the
  // accepted last beat so the next codeword loads without a bubble.
  always_comb begin
    ser_valid  = (state == SEND);
    ser_sof    = ser_valid && (beat_cnt == '0);
    ser_eof    = ser_valid && (beat_cnt == LAST_BEAT);
    frame_done = ser_eof && ser_ready;
    cw_ready   = rst_n && ((state == IDLE) || frame_done);
    accept     = cw_valid && cw_ready;
    shift_en   = ser_valid && ser_ready && !ser_eof;
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = SEND;
        end
      end
      SEND: begin
        if (frame_done) begin
          next_state = accept ? SEND : IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

`ifdef LDPC_SER_PARITY_EN
  logic frame_xor;

  ldpc_ser_lane_shifter #(
    .CW_WIDTH (CW_WIDTH),
    .LANE_W   (LANE_W)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .shift     (shift_en),
    .load_data (cw_data),
    .lane      (ser_data),
    .frame_xor (frame_xor)
  );

  assign ser_parity = ser_eof && frame_xor;
`else
  ldpc_ser_lane_shifter #(
    .CW_WIDTH (CW_WIDTH),
    .LANE_W   (LANE_W)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .shift     (shift_en),
    .load_data (cw_data),
    .lane      (ser_data)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_ldpc_codeword_serializer.sv
`default_nettype none
// ============================================================================
// Module : tb_ldpc_codeword_serializer
// Brief  : Self-checking bench for ldpc_codeword_serializer. Expected beats
//          come from slicing the stimulus codewords directly; frame counts
//          from the number of frames sent. Parity scenario runs when
//          LDPC_SER_PARITY_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ldpc_codeword_serializer;

  localparam int CW   = 2048;
  localparam int LANE = 32;
  localparam int FW   = 4;
  localparam int NB   = CW / LANE;

  logic            clk;
  logic            rst_n;
  logic            cw_valid;
  logic [CW-1:0]   cw_data;
  logic            cw_ready;
  logic            ser_valid;
  logic [LANE-1:0] ser_data;
  logic            ser_sof;
  logic            ser_eof;
  logic            ser_ready;
  logic [FW-1:0]   frame_cnt;
`ifdef LDPC_SER_PARITY_EN
  logic            ser_parity;
`endif

  ldpc_codeword_serializer #(
    .CW_WIDTH (CW),
    .LANE_W   (LANE),
    .FCNT_W   (FW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cw_valid  (cw_valid),
    .cw_data   (cw_data),
    .cw_ready  (cw_ready),
    .ser_valid (ser_valid),
    .ser_data  (ser_data),
    .ser_sof   (ser_sof),
    .ser_eof   (ser_eof),
    .ser_ready (ser_ready),
    .frame_cnt (frame_cnt)
`ifdef LDPC_SER_PARITY_EN
    ,
    .ser_parity (ser_parity)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic            valid;
    logic [LANE-1:0] data;
    logic            sof;
    logic            eof;
    logic            sready;
    logic            cwready;
    logic            par;
  } obs_t;

  obs_t          log_q[$];
  logic [CW-1:0] cw_arr[$];
  int            nchk  = 0;
  int            npass = 0;
  int            exp_fcnt = 0;

  // Reference: beat k of a codeword is the k-th LANE slice counted from the MSB.
  function automatic logic [LANE-1:0] exp_beat(input logic [CW-1:0] cw, input int k);
    return cw[CW-1-k*LANE -: LANE];
  endfunction

  function automatic logic [CW-1:0] rand_cw();
    logic [CW-1:0] v;
    for (int i = 0; i < NB; i++) v[i*LANE +: LANE] = $urandom;
    return v;
  endfunction

  // Streams cw_arr[0..n-1] through the DUT, logging every cycle. Called at
  // posedge+1; returns at posedge+1 after the last eof beat is accepted.
  task automatic run_stream(input int n, input int stall_pct, output bit timed_out);
    int   idx;
    int   done;
    int   cyc;
    obs_t o;
    idx = 0; done = 0; cyc = 0; timed_out = 1'b0;
    log_q.delete();
    while (done < n) begin
      if (cyc > n * NB * 4 + 100) begin
        timed_out = 1'b1;
        break;
      end
      cw_valid  = (idx < n);
      cw_data   = (idx < n) ? cw_arr[idx] : '0;
      ser_ready = ($urandom_range(99) >= stall_pct);
      #1;
      o.valid = ser_valid; o.data = ser_data; o.sof = ser_sof; o.eof = ser_eof;
      o.sready = ser_ready; o.cwready = cw_ready;
`ifdef LDPC_SER_PARITY_EN
      o.par = ser_parity;
`else
      o.par = 1'b0;
`endif
      log_q.push_back(o);
      if (cw_valid && cw_ready) idx++;
      if (ser_valid && ser_ready && ser_eof) done++;
      @(posedge clk); #1;
      cyc++;
    end
    cw_valid  = 1'b0;
    ser_ready = 1'b0;
  endtask

  // Compares accepted beats in log_q against the codewords in cw_arr; returns bad beat count.
  task automatic score_beats(input int n, output int bad, output int nbeats);
    int k;
    bad = 0; nbeats = 0; k = 0;
    foreach (log_q[i]) begin
      if (log_q[i].valid && log_q[i].sready) begin
        if (k < n * NB) begin
          if (log_q[i].data !== exp_beat(cw_arr[k / NB], k % NB) ||
              log_q[i].sof !== ((k % NB) == 0) || log_q[i].eof !== ((k % NB) == NB - 1)) begin
            if (bad == 0)
              $display("  beat %0d: got %h sof=%b eof=%b want %h", k, log_q[i].data,
                       log_q[i].sof, log_q[i].eof, exp_beat(cw_arr[k / NB], k % NB));
            bad++;
          end
        end
        k++;
      end
    end
    nbeats = k;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cw_valid = 1'b0; ser_ready = 1'b0; cw_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_fcnt = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cw_valid = 1'b1; cw_data = '1; ser_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if (ser_valid !== 1'b0 || ser_sof !== 1'b0 || ser_eof !== 1'b0)
      $display("FAIL reset_outputs: valid=%b sof=%b eof=%b want 0 0 0", ser_valid, ser_sof, ser_eof);
    else npass++;
    nchk++;
    if (frame_cnt !== '0) $display("FAIL reset_fcnt: got %0d want 0", frame_cnt);
    else npass++;
    nchk++;
    if (cw_ready !== 1'b0) $display("FAIL reset_cw_ready: got %b want 0", cw_ready);
    else npass++;
    cw_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    nchk++;
    if (cw_ready !== 1'b1) $display("FAIL idle_cw_ready: got %b want 1", cw_ready);
    else npass++;
    exp_fcnt = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    logic [CW-1:0] cw;
    bit            to;
    int            bad, nb, nvalid, first, last;
    cw = '0; cw[CW-1] = 1'b1; cw[0] = 1'b1;
    cw_arr.delete(); cw_arr.push_back(cw);
    run_stream(1, 0, to);
    exp_fcnt += 1;
    nchk++;
    if (to) $display("FAIL single_timeout: frame did not complete");
    else npass++;
    nvalid = 0; first = -1; last = -1;
    foreach (log_q[i]) if (log_q[i].valid) begin
      nvalid++;
      if (first < 0) first = i;
      last = i;
    end
    nchk++;
    if (nvalid != NB) $display("FAIL single_beat_count: got %0d want %0d", nvalid, NB);
    else npass++;
    nchk++;
    if (first != 1) $display("FAIL single_latency: first beat at cycle %0d want 1", first);
    else npass++;
    if (first >= 0) begin
      nchk++;
      if (log_q[first].data !== 32'h8000_0000 || log_q[first].sof !== 1'b1)
        $display("FAIL single_beat0: got %h sof=%b want 80000000 sof=1", log_q[first].data, log_q[first].sof);
      else npass++;
      nchk++;
      if (log_q[last].data !== 32'h0000_0001 || log_q[last].eof !== 1'b1)
        $display("FAIL single_beat63: got %h eof=%b want 00000001 eof=1", log_q[last].data, log_q[last].eof);
      else npass++;
    end
    score_beats(1, bad, nb);
    nchk++;
    if (bad != 0) $display("FAIL single_beats: %0d bad beats, want 0", bad);
    else npass++;
    nchk++;
    if (frame_cnt !== FW'(exp_fcnt)) $display("FAIL single_fcnt: got %0d want %0d", frame_cnt, exp_fcnt % 16);
    else npass++;
  endtask

  task automatic test_stall();
    bit to;
    int bad, nb, unstable, stalls;
    cw_arr.delete(); cw_arr.push_back(rand_cw());
    run_stream(1, 50, to);
    exp_fcnt += 1;
    nchk++;
    if (to) $display("FAIL stall_timeout: frame did not complete");
    else npass++;
    score_beats(1, bad, nb);
    nchk++;
    if (bad != 0 || nb != NB) $display("FAIL stall_reassembly: bad=%0d beats=%0d want 0 and %0d", bad, nb, NB);
    else npass++;
    unstable = 0; stalls = 0;
    for (int i = 0; i + 1 < log_q.size(); i++) begin
      if (log_q[i].valid && !log_q[i].sready) begin
        stalls++;
        if (!log_q[i+1].valid || log_q[i+1].data !== log_q[i].data ||
            log_q[i+1].sof !== log_q[i].sof || log_q[i+1].eof !== log_q[i].eof)
          unstable++;
      end
    end
    nchk++;
    if (unstable != 0) $display("FAIL stall_hold: %0d of %0d stall cycles changed output, want 0", unstable, stalls);
    else npass++;
    nchk++;
    if (frame_cnt !== FW'(exp_fcnt)) $display("FAIL stall_fcnt: got %0d want %0d", frame_cnt, exp_fcnt % 16);
    else npass++;
  endtask

  task automatic test_back_to_back();
    bit to;
    int bad, nb, bubbles, rdy_bad, first;
    cw_arr.delete();
    repeat (3) cw_arr.push_back(rand_cw());
    run_stream(3, 0, to);
    exp_fcnt += 3;
    nchk++;
    if (to) $display("FAIL b2b_timeout: frames did not complete");
    else npass++;
    first = -1;
    foreach (log_q[i]) if (log_q[i].valid && first < 0) first = i;
    nchk++;
    if (log_q.size() == 0 || log_q[0].cwready !== 1'b1) $display("FAIL b2b_idle_ready: cw_ready not high at idle start");
    else npass++;
    bubbles = 0; rdy_bad = 0;
    for (int k = 0; k < 3 * NB; k++) begin
      if (first < 0 || first + k >= log_q.size()) bubbles++;
      else begin
        if (!log_q[first+k].valid) bubbles++;
        if (log_q[first+k].cwready !== ((k % NB) == NB - 1)) rdy_bad++;
      end
    end
    nchk++;
    if (bubbles != 0) $display("FAIL b2b_bubbles: got %0d bubble cycles want 0", bubbles);
    else npass++;
    nchk++;
    if (rdy_bad != 0) $display("FAIL b2b_cw_ready: %0d beats with wrong cw_ready, want 0", rdy_bad);
    else npass++;
    score_beats(3, bad, nb);
    nchk++;
    if (bad != 0 || nb != 3 * NB) $display("FAIL b2b_beats: bad=%0d beats=%0d want 0 and %0d", bad, nb, 3 * NB);
    else npass++;
    nchk++;
    if (frame_cnt !== FW'(exp_fcnt)) $display("FAIL b2b_fcnt: got %0d want %0d", frame_cnt, exp_fcnt % 16);
    else npass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [CW-1:0] cw;
    bit            to;
    int            bad, nb, first;
    cw = rand_cw();
    cw_valid = 1'b1; cw_data = cw; ser_ready = 1'b1;
    @(posedge clk); #1;
    cw_valid = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    nchk++;
    if (ser_valid !== 1'b1 || ser_data !== exp_beat(cw, 20))
      $display("FAIL mid_beat20: valid=%b data=%h want 1 %h", ser_valid, ser_data, exp_beat(cw, 20));
    else npass++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    cw_valid = 1'b1; cw_data = rand_cw();
    #1;
    nchk++;
    if (ser_valid !== 1'b0 || ser_sof !== 1'b0 || ser_eof !== 1'b0)
      $display("FAIL mid_reset_valid: valid=%b sof=%b eof=%b want 0 0 0", ser_valid, ser_sof, ser_eof);
    else npass++;
    nchk++;
    if (frame_cnt !== '0) $display("FAIL mid_reset_fcnt: got %0d want 0", frame_cnt);
    else npass++;
    nchk++;
    if (cw_ready !== 1'b0) $display("FAIL mid_reset_cw_ready: got %b want 0", cw_ready);
    else npass++;
    @(posedge clk); #1;
    nchk++;
    if (cw_ready !== 1'b0 || ser_valid !== 1'b0)
      $display("FAIL mid_reset_hold: cw_ready=%b valid=%b want 0 0", cw_ready, ser_valid);
    else npass++;
    cw_valid = 1'b0;
    rst_n = 1'b1;
    exp_fcnt = 0;
    @(posedge clk); #1;
    cw_arr.delete(); cw_arr.push_back(rand_cw());
    run_stream(1, 0, to);
    exp_fcnt += 1;
    first = -1;
    foreach (log_q[i]) if (log_q[i].valid && first < 0) first = i;
    nchk++;
    if (to || first < 0 || log_q[first].sof !== 1'b1 || log_q[first].data !== exp_beat(cw_arr[0], 0))
      $display("FAIL mid_restart_sof: timeout=%0b first=%0d, want clean sof beat", to, first);
    else npass++;
    score_beats(1, bad, nb);
    nchk++;
    if (bad != 0 || nb != NB) $display("FAIL mid_restart_beats: bad=%0d beats=%0d want 0 and %0d", bad, nb, NB);
    else npass++;
    nchk++;
    if (frame_cnt !== FW'(exp_fcnt)) $display("FAIL mid_restart_fcnt: got %0d want %0d", frame_cnt, exp_fcnt % 16);
    else npass++;
  endtask

  task automatic test_fcnt_wrap();
    bit to;
    do_reset();
    cw_arr.delete();
    repeat (17) cw_arr.push_back(rand_cw());
    run_stream(17, 0, to);
    exp_fcnt += 17;
    nchk++;
    if (to) $display("FAIL wrap_timeout: frames did not complete");
    else npass++;
    nchk++;
    if (frame_cnt !== FW'(exp_fcnt % 16)) $display("FAIL wrap_fcnt: got %0d want %0d", frame_cnt, exp_fcnt % 16);
    else npass++;
  endtask

`ifdef LDPC_SER_PARITY_EN
  task automatic test_parity();
    logic [CW-1:0] cw;
    bit            to;
    int            eof_bad, other_bad, pos;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) cw = '1;
      else begin
        cw = '0; pos = $urandom_range(CW - 1); cw[pos] = 1'b1;
      end
      cw_arr.delete(); cw_arr.push_back(cw);
      run_stream(1, 30, to);
      exp_fcnt += 1;
      eof_bad = 0; other_bad = 0;
      foreach (log_q[i]) begin
        if (log_q[i].valid && log_q[i].eof) begin
          if (log_q[i].par !== (^cw)) eof_bad++;
        end else if (log_q[i].par !== 1'b0) other_bad++;
      end
      nchk++;
      if (to || eof_bad != 0)
        $display("FAIL parity_eof_%0d: %0d eof cycles wrong, want parity %b", t, eof_bad, ^cw);
      else npass++;
      nchk++;
      if (other_bad != 0) $display("FAIL parity_other_%0d: %0d non-eof cycles high, want 0", t, other_bad);
      else npass++;
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; cw_valid = 1'b0; cw_data = '0; ser_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_stall();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef LDPC_SER_PARITY_EN
    test_parity();
`endif
    test_fcnt_wrap();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
`default_nettype wire
